// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the word RAM port. Converts RV32I byte/half/word
// accesses into one or two word-aligned RAM cycles with lane strobes and load extension.
module lsu_mem_initiator #(
   parameter int unsigned MEM_BYTES        = 512,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_r,
   output logic [3:0]  mem_w,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   // state | meaning
   // IDLE  | ready for a request
   // ACC0  | first (lower) word access
   // ACC1  | second (upper) word access of a split request
   // RESP  | one-cycle response pulse
   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t state_q, state_d;

   logic [2:0]  size;
   logic [1:0]  off;
   logic [3:0]  end_off;
   logic        split;
   logic        illegal;
   logic [32:0] last_byte;
   logic        out_of_range;
   logic        req_err;
   logic [4:0]  ones;
   logic [6:0]  mask;
   logic [7:0]  mask8;
   logic [63:0] wdata_sh;
   logic [63:0] wdata64;

   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  off_q;
   logic        split_q;
   logic [6:0]  mask_q;
   logic [63:0] wdata64_q;
   logic [29:0] word_addr_q;
   logic [31:0] lo_q;
   logic [31:0] resp_rdata_q;
   logic        resp_err_q;

   logic [63:0] captured;
   logic [31:0] shifted;
   logic [31:0] load_ext;
   logic        last_acc;

   // Decode of the live request, used only at the acceptance edge
   always_comb begin
      case (req_funct3[1:0])
         2'b01:   size = 3'd2;
         2'b10:   size = 3'd4;
         default: size = 3'd1;
      endcase
      off     = req_addr[1:0];
      end_off = {2'b00, off} + {1'b0, size};
      split   = end_off > 4'd4;
      if (req_we)
         illegal = req_funct3[2] | (req_funct3 == 3'b011);
      else
         illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) | (req_funct3 == 3'b111);
      last_byte    = {1'b0, req_addr} + 33'(size) - 33'd1;
      out_of_range = last_byte >= 33'(MEM_BYTES);
      req_err      = illegal | out_of_range | (split & !ALLOW_MISALIGNED);
      ones     = (5'd1 << size) - 5'd1;
      mask     = 7'(ones) << off;
      mask8    = {1'b0, mask};
      wdata_sh = {32'h0, req_wdata} << {off, 3'b000};
      wdata64  = 64'h0;
      for (int i = 0; i < 8; i++)
         wdata64[8*i +: 8] = mask8[i] ? wdata_sh[8*i +: 8] : 8'h00;
   end

   // Load extension; the final word is taken straight from the RAM at the closing edge
   always_comb begin
      captured = (state_q == ACC1) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
      shifted  = 32'(captured >> {off_q, 3'b000});
      case (funct3_q)
         3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {24'h0, shifted[7:0]};
         3'b101:  load_ext = {16'h0, shifted[15:0]};
         default: load_ext = shifted;
      endcase
      last_acc = ((state_q == ACC0) && !split_q) || (state_q == ACC1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      mem_r     = 1'b0;
      mem_w     = 4'b0000;
      mem_addr  = 32'h0;
      mem_wdata = 32'h0;
      case (state_q)
         IDLE: begin
            if (req_valid)
               state_d = req_err ? RESP : ACC0;
         end
         ACC0: begin
            mem_r     = !we_q;
            mem_w     = we_q ? mask_q[3:0] : 4'b0000;
            mem_addr  = {word_addr_q, 2'b00};
            mem_wdata = we_q ? wdata64_q[31:0] : 32'h0;
            state_d   = split_q ? ACC1 : RESP;
         end
         ACC1: begin
            mem_r     = !we_q;
            mem_w     = we_q ? {1'b0, mask_q[6:4]} : 4'b0000;
            mem_addr  = {word_addr_q + 30'd1, 2'b00};
            mem_wdata = we_q ? wdata64_q[63:32] : 32'h0;
            state_d   = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q         <= 1'b0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         split_q      <= 1'b0;
         mask_q       <= 7'h0;
         wdata64_q    <= 64'h0;
         word_addr_q  <= 30'h0;
         lo_q         <= 32'h0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && req_valid) begin
            we_q        <= req_we;
            funct3_q    <= req_funct3;
            off_q       <= off;
            split_q     <= split;
            mask_q      <= mask;
            wdata64_q   <= wdata64;
            word_addr_q <= req_addr[31:2];
            if (req_err) begin
               resp_err_q   <= 1'b1;
               resp_rdata_q <= 32'h0;
            end
         end
         if (state_q == ACC0)
            lo_q <= mem_rdata;
         if (last_acc) begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= we_q ? 32'h0 : load_ext;
         end
      end
   end

   assign req_ready  = (state_q == IDLE) && rst_n;
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a behavioural word RAM that commits on negedge.
// A second instance with misaligned splitting disabled covers the misalignment error.
module tb_lsu_mem_initiator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_valid_b = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        req_ready, resp_valid, resp_err, mem_r;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_w;
   logic        req_ready_b, resp_valid_b, resp_err_b, mem_r_b;
   logic [31:0] resp_rdata_b, mem_addr_b, mem_wdata_b;
   logic [31:0] mem_rdata_b = 32'h0;
   logic [3:0]  mem_w_b;

   logic [31:0] ram [0:127];
   logic        pl_en = 1'b0;
   logic [31:0] pl_addr = 32'h0, pl_data = 32'h0;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   lsu_mem_initiator #(.MEM_BYTES(512), .ALLOW_MISALIGNED(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata));

   lsu_mem_initiator #(.MEM_BYTES(512), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
      .mem_r(mem_r_b), .mem_w(mem_w_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b));

   assign mem_rdata = mem_r ? ram[mem_addr[8:2]] : 32'h0;

   always @(negedge clk) begin
      if (pl_en)
         ram[pl_addr[8:2]] <= pl_data;
      for (int i = 0; i < 4; i++)
         if (mem_w[i])
            ram[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(posedge clk);
      #1;
      pl_en = 1'b1; pl_addr = addr; pl_data = data;
      step();
      pl_en = 1'b0;
   endtask

   // Returns 1ns after the acceptance edge, i.e. inside the first cycle after it
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit to_b);
      int guard;
      guard = 0;
      @(negedge clk);
      while (!(to_b ? req_ready_b : req_ready) && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 20)
         chk("ready_timeout", {31'h0, to_b ? req_ready_b : req_ready}, 32'd1);
      req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      if (to_b) req_valid_b = 1'b1;
      else      req_valid   = 1'b1;
      step();
      req_valid = 1'b0; req_valid_b = 1'b0;
   endtask

   // Aligned load: ACC cycle then response
   task automatic load1(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
      issue(1'b0, f3, addr, 32'h0, 1'b0);
      chk({tag, "_acc_r"}, {31'h0, mem_r}, 32'd1);
      step();
      chk({tag, "_vld"}, {31'h0, resp_valid}, 32'd1);
      chk({tag, "_data"}, resp_rdata, exp);
   endtask

   initial begin
      #12;
      chk("rst_ready", {31'h0, req_ready}, 32'd0);
      chk("rst_mem_r", {31'h0, mem_r}, 32'd0);
      chk("rst_mem_w", {28'h0, mem_w}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_resp", {30'h0, resp_valid, resp_err}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", {31'h0, req_ready}, 32'd1);

      preload(32'h10, 32'h8899AABB);
      preload(32'h14, 32'h11223344);

      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      chk("lw_c1_r", {31'h0, mem_r}, 32'd1);
      chk("lw_c1_w", {28'h0, mem_w}, 32'd0);
      chk("lw_c1_addr", mem_addr, 32'h10);
      chk("lw_c1_vld", {31'h0, resp_valid}, 32'd0);
      step();
      chk("lw_c2_vld", {31'h0, resp_valid}, 32'd1);
      chk("lw_c2_ready", {31'h0, req_ready}, 32'd0);
      chk("lw_data", resp_rdata, 32'h8899AABB);
      chk("lw_err", {31'h0, resp_err}, 32'd0);
      chk("lw_c2_r", {31'h0, mem_r}, 32'd0);
      step();
      chk("lw_c3_vld", {31'h0, resp_valid}, 32'd0);
      chk("lw_hold", resp_rdata, 32'h8899AABB);
      chk("lw_c3_ready", {31'h0, req_ready}, 32'd1);

      load1("lb",  3'b000, 32'h13, 32'hFFFFFF88);
      load1("lbu", 3'b100, 32'h13, 32'h00000088);
      load1("lh",  3'b001, 32'h12, 32'hFFFF8899);
      load1("lhu", 3'b101, 32'h12, 32'h00008899);
      load1("lb0", 3'b000, 32'h10, 32'hFFFFFFBB);

      issue(1'b1, 3'b000, 32'h12, 32'hFFFFFF5A, 1'b0);
      chk("sb_w", {28'h0, mem_w}, 32'b0100);
      chk("sb_r", {31'h0, mem_r}, 32'd0);
      chk("sb_addr", mem_addr, 32'h10);
      chk("sb_wdata", mem_wdata, 32'h005A0000);
      step();
      chk("sb_vld", {31'h0, resp_valid}, 32'd1);
      chk("sb_rdata", resp_rdata, 32'h0);
      chk("sb_w_resp", {28'h0, mem_w}, 32'd0);
      load1("sb_rb", 3'b010, 32'h10, 32'h885AAABB);

      issue(1'b0, 3'b001, 32'h13, 32'h0, 1'b0);
      chk("lhs_a0_addr", mem_addr, 32'h10);
      chk("lhs_a0_r", {31'h0, mem_r}, 32'd1);
      step();
      chk("lhs_a1_addr", mem_addr, 32'h14);
      chk("lhs_a1_r", {31'h0, mem_r}, 32'd1);
      chk("lhs_a1_vld", {31'h0, resp_valid}, 32'd0);
      step();
      chk("lhs_vld", {31'h0, resp_valid}, 32'd1);
      chk("lhs_data", resp_rdata, 32'h00004488);

      issue(1'b1, 3'b010, 32'h0E, 32'hDEADBEEF, 1'b0);
      chk("sws_a0_w", {28'h0, mem_w}, 32'b1100);
      chk("sws_a0_addr", mem_addr, 32'h0C);
      chk("sws_a0_wdata", mem_wdata, 32'hBEEF0000);
      step();
      chk("sws_a1_w", {28'h0, mem_w}, 32'b0011);
      chk("sws_a1_addr", mem_addr, 32'h10);
      chk("sws_a1_wdata", mem_wdata, 32'h0000DEAD);
      step();
      chk("sws_vld", {31'h0, resp_valid}, 32'd1);
      load1("sws_rb", 3'b010, 32'h10, 32'h885ADEAD);
      load1("sws_rb_h", 3'b101, 32'h0E, 32'h0000BEEF);

      issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b0);
      chk("ef3_vld", {31'h0, resp_valid}, 32'd1);
      chk("ef3_err", {31'h0, resp_err}, 32'd1);
      chk("ef3_rdata", resp_rdata, 32'h0);
      chk("ef3_mem", {27'h0, mem_r, mem_w}, 32'd0);
      step();
      chk("ef3_hold", {30'h0, resp_valid, resp_err}, 32'b01);

      issue(1'b1, 3'b010, 32'h1FE, 32'h12345678, 1'b0);
      chk("erng_vld", {31'h0, resp_valid}, 32'd1);
      chk("erng_err", {31'h0, resp_err}, 32'd1);
      chk("erng_mem", {27'h0, mem_r, mem_w}, 32'd0);

      issue(1'b1, 3'b010, 32'h1FC, 32'h12345678, 1'b0);
      chk("top_w", {28'h0, mem_w}, 32'b1111);
      step();
      chk("top_err", {30'h0, resp_valid, resp_err}, 32'b10);

      issue(1'b1, 3'b100, 32'h10, 32'h0, 1'b0);
      chk("est_f3_err", {30'h0, resp_valid, resp_err}, 32'b11);
      chk("est_f3_mem", {27'h0, mem_r, mem_w}, 32'd0);

      issue(1'b1, 3'b001, 32'h03, 32'h00001234, 1'b1);
      chk("na_vld", {31'h0, resp_valid_b}, 32'd1);
      chk("na_err", {31'h0, resp_err_b}, 32'd1);
      chk("na_mem", {27'h0, mem_r_b, mem_w_b}, 32'd0);
      issue(1'b1, 3'b001, 32'h02, 32'h00001234, 1'b1);
      chk("na_ok_w", {28'h0, mem_w_b}, 32'b1100);
      chk("na_ok_wdata", mem_wdata_b, 32'h12340000);
      step();
      chk("na_ok_err", {30'h0, resp_valid_b, resp_err_b}, 32'b10);

      issue(1'b1, 3'b010, 32'h1E, 32'hCAFEBABE, 1'b0);
      chk("rmid_a0_w", {28'h0, mem_w}, 32'b1100);
      step();
      chk("rmid_a1_w", {28'h0, mem_w}, 32'b0011);
      chk("rmid_a1_addr", mem_addr, 32'h20);
      rst_n = 1'b0;
      #1;
      chk("rmid_w_drop", {28'h0, mem_w}, 32'd0);
      chk("rmid_addr_drop", mem_addr, 32'h0);
      chk("rmid_ready", {31'h0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rmid_ready_rel", {31'h0, req_ready}, 32'd1);
      load1("rmid_rb", 3'b101, 32'h1E, 32'h0000BABE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
